// File: rtl/lcd_char_driver.sv
// HD44780 16x2 write-only controller: power-on init, then continuous two-line refresh.
// Optional inter-frame idle gap enabled by defining LCD_REFRESH_GAP_EN.
module lcd_char_driver #(
  parameter int unsigned POWERON_WAIT = 750000,
  parameter int unsigned SETUP_CYC    = 4,
  parameter int unsigned E_PULSE      = 12,
  parameter int unsigned CMD_WAIT     = 2500,
  parameter int unsigned CLEAR_WAIT   = 90000,
  parameter int unsigned REFRESH_GAP  = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_in,
  output logic [4:0] index,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data,
  output logic       init_done,
  output logic       frame_done
);

  localparam int unsigned MaxA    = (POWERON_WAIT > CLEAR_WAIT) ? POWERON_WAIT : CLEAR_WAIT;
  localparam int unsigned MaxB    = (REFRESH_GAP > CMD_WAIT) ? REFRESH_GAP : CMD_WAIT;
  localparam int unsigned MaxC    = (SETUP_CYC > E_PULSE) ? SETUP_CYC : E_PULSE;
  localparam int unsigned MaxAB   = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned MaxWait = (MaxAB > MaxC) ? MaxAB : MaxC;
  localparam int unsigned CntW    = $clog2(MaxWait + 1);

  localparam logic [CntW-1:0] PwrLast   = CntW'(POWERON_WAIT - 1);
  localparam logic [CntW-1:0] SetupLast = CntW'(SETUP_CYC - 1);
  localparam logic [CntW-1:0] EhighLast = CntW'(E_PULSE - 1);
  localparam logic [CntW-1:0] CmdLast   = CntW'(CMD_WAIT - 1);
  localparam logic [CntW-1:0] ClearLast = CntW'(CLEAR_WAIT - 1);
`ifdef LCD_REFRESH_GAP_EN
  localparam logic [CntW-1:0] GapLast   = CntW'(REFRESH_GAP - 1);
`endif

  typedef enum logic [2:0] {
    S_PWR,
    S_SETUP,
    S_EHIGH,
    S_WAIT,
    S_FETCH
`ifdef LCD_REFRESH_GAP_EN
    , S_GAP
`endif
  } state_t;

  state_t            r_state;
  logic [CntW-1:0]   r_cnt;
  logic [2:0]        r_init_step;
  logic [2:0]        w_next_step;
  logic [CntW-1:0]   w_wait_last;

  function automatic logic [7:0] init_cmd(input logic [2:0] step);
    unique case (step)
      3'd0, 3'd1: init_cmd = 8'h38;
      3'd2:       init_cmd = 8'h0C;
      3'd3:       init_cmd = 8'h06;
      default:    init_cmd = 8'h01;
    endcase
  endfunction

  assign lcd_rw      = 1'b0;
  assign w_next_step = r_init_step + 3'd1;

  // The clear-display command needs the long settle time.
  always_comb begin
    w_wait_last = CmdLast;
    if (!lcd_rs && lcd_data == 8'h01) w_wait_last = ClearLast;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_PWR;
      r_cnt       <= '0;
      r_init_step <= 3'd0;
      index       <= 5'd0;
      lcd_e       <= 1'b0;
      lcd_rs      <= 1'b0;
      lcd_data    <= 8'h00;
      init_done   <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (r_state)
        S_PWR: begin
          if (r_cnt == PwrLast) begin
            r_cnt    <= '0;
            lcd_rs   <= 1'b0;
            lcd_data <= init_cmd(3'd0);
            r_state  <= S_SETUP;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        S_SETUP: begin
          if (r_cnt == SetupLast) begin
            r_cnt   <= '0;
            lcd_e   <= 1'b1;
            r_state <= S_EHIGH;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        S_EHIGH: begin
          if (r_cnt == EhighLast) begin
            r_cnt   <= '0;
            lcd_e   <= 1'b0;
            r_state <= S_WAIT;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        S_WAIT: begin
          if (r_cnt == w_wait_last) begin
            r_cnt <= '0;
            if (!init_done) begin
              if (r_init_step == 3'd4) begin
                init_done <= 1'b1;
                lcd_data  <= 8'h80;
              end else begin
                r_init_step <= w_next_step;
                lcd_data    <= init_cmd(w_next_step);
              end
              r_state <= S_SETUP;
            end else if (!lcd_rs) begin
              r_state <= S_FETCH;
            end else if (index == 5'd31) begin
              index      <= 5'd0;
              frame_done <= 1'b1;
`ifdef LCD_REFRESH_GAP_EN
              r_state    <= S_GAP;
`else
              lcd_rs     <= 1'b0;
              lcd_data   <= 8'h80;
              r_state    <= S_SETUP;
`endif
            end else if (index[3:0] == 4'hF) begin
              index    <= index + 5'd1;
              lcd_rs   <= 1'b0;
              lcd_data <= 8'hC0;
              r_state  <= S_SETUP;
            end else begin
              index   <= index + 5'd1;
              r_state <= S_FETCH;
            end
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        S_FETCH: begin
          // Source is registered: char_in reflects index only on the second cycle.
          if (r_cnt == CntW'(1)) begin
            r_cnt    <= '0;
            lcd_rs   <= 1'b1;
            lcd_data <= char_in;
            r_state  <= S_SETUP;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
`ifdef LCD_REFRESH_GAP_EN
        S_GAP: begin
          if (r_cnt == GapLast) begin
            r_cnt    <= '0;
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h80;
            r_state  <= S_SETUP;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
`endif
        default: begin
          r_cnt   <= '0;
          r_state <= S_PWR;
        end
      endcase
    end
  end

endmodule
